aes_ctr_sched: RTL and testbench
================================

// Module: aes_ctr_sched
// PURPOSE
// - CTR-mode sequencer for the free-running AES-256 pipeline (aes_256, no stall input, fixed latency).
// - Generates counter blocks, issues one per accepted plaintext beat and holds the core key stable for the whole message.
// - Realigns returning keystream with buffered plaintext, XORs the two and streams ciphertext out with backpressure.
// - Sits between the host stream interface and the aes_256 instance in the aes_ctr app.
// PARAMETERS
// - AES_LAT     29  core latency in cycles, core_state sample to matching core_out.
// - FIFO_DEPTH  32  plaintext/keystream FIFO depth; power of two, must be >= AES_LAT+2.
// - CTR_W       32  low bits of the counter block that increment; upper 128-CTR_W bits are fixed nonce.
// PORTS
// - aclk        in   1    clock
// - aresetn     in   1    asynchronous active-low reset
// - cfg_key     in   256  key; sampled on an accepted cfg_start
// - cfg_iv      in   128  initial counter block; sampled on an accepted cfg_start
// - cfg_start   in   1    start pulse; accepted only in IDLE
// - busy        out  1    high in RUN or DRAIN
// - done        out  1    one-cycle pulse on the DRAIN->IDLE transition
// - ctr_wrap    out  1    sticky; low CTR_W counter bits wrapped this message; cleared on start
// - s_data      in   128  plaintext beat
// - s_last      in   1    last plaintext beat of the message
// - s_valid/s_ready  in/out  1  input handshake
// - m_data      out  128  ciphertext beat
// - m_last      out  1    last ciphertext beat
// - m_valid/m_ready  out/in  1  output handshake
// - core_state  out  128  counter block to the core
// - core_key    out  256  key to the core
// - core_out    in   128  keystream from the core
// BEHAVIOUR
// - Reset: state IDLE; outputs busy, done, ctr_wrap, s_ready, m_valid, m_last = 0; m_data, core_state, core_key = 0.
//   Reset also empties both FIFOs and clears the valid shift register. Reset mid-message discards all in-flight data.
// - FSM:
//   - IDLE -> RUN on cfg_start: key_r<=cfg_key, ctr<=cfg_iv, ctr_wrap<=0.
//   - RUN -> DRAIN on an accepted beat with s_last=1.
//   - DRAIN -> IDLE when the pt FIFO, ks FIFO and valid shift register are all empty; done pulses for 1 cycle.
//   - cfg_start in RUN or DRAIN is ignored. cfg_start and reset together: reset wins.
// - Handshake: s_ready = (state==RUN) & !pt_full. A beat is accepted when s_valid & s_ready.
// - Issue (same cycle as acceptance):
//   - core_state<=ctr and vsr[0]<=1; push {s_data,s_last} into the pt FIFO.
//   - Then ctr[CTR_W-1:0]<=ctr[CTR_W-1:0]+1, mod 2^CTR_W; upper bits are never modified.
//   - Increment from all-ones sets ctr_wrap. Cycles with no issue shift vsr with 0; core_state holds its last value.
// - core_key = key_r, constant from start until the next start; key changes happen only in IDLE.
// - vsr is an AES_LAT-bit shift register. When vsr[AES_LAT-1]=1, core_out is pushed into the ks FIFO that cycle.
// - No overflow, by construction: pt occupancy = in-flight + ks occupancy <= FIFO_DEPTH, so the ks FIFO cannot overflow.
// - Output:
//   - m_valid = !ks_empty. m_data = pt_head.data ^ ks_head. m_last = pt_head.last.
//   - Both FIFOs pop on m_valid & m_ready.
//   - m_data/m_last hold stable while m_valid & !m_ready.
// - Ordering: strict FIFO, so beat n of a message is XORed with E(key, iv+n).
// - Single-beat message (first beat has s_last=1) is legal: RUN->DRAIN immediately.
// - Full: s_ready drops while pt_full. Input is accepted again the cycle after a pop frees a slot.
// - Simultaneous push and pop on either FIFO keeps occupancy unchanged and is legal, including when the FIFO is full.
// CONFIGURATION
// - AES_CTR_STATS_EN defined: adds outputs stat_blocks[31:0] and stat_stall[31:0].
//   - stat_blocks counts output handshakes; stat_stall counts cycles with s_valid & !s_ready in RUN.
//   - Both saturate at all-ones and clear on an accepted cfg_start and on reset.
// - AES_CTR_STATS_EN not defined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
// - FIPS-197 vector:
//   - Stimulus: cfg_key=000102..1f, cfg_iv=00112233445566778899aabbccddeeff, one beat s_data=0 with s_last=1, m_ready=1.
//   - Expected: m_data=8ea2b7ca516745bfeafc49904b496089 with m_last=1, m_valid rising AES_LAT+1 cycles after acceptance, then a done pulse.
// - Counter wrap (CTR_W=32):
//   - Stimulus: iv low word=ffffffff, 3 beats.
//   - Expected: core_state low words ffffffff, 00000000, 00000001; upper 96 bits unchanged; ctr_wrap=1.
// - Backpressure:
//   - Stimulus: m_ready=0, feed 40 beats.
//   - Expected: exactly FIFO_DEPTH beats accepted, then s_ready=0; after m_ready=1 all 40 outputs in order and match the model.
// - Random handshakes:
//   - Stimulus: 1000 beats, random s_valid and m_ready (50%).
//   - Expected: output equals the software AES-CTR model; no beat lost or duplicated.
// - Start in RUN:
//   - Stimulus: cfg_start with a new key mid-message.
//   - Expected: ignored; the remaining beats use the old key.
//   - Then: a start after done uses the new key.
// - Reset mid-message:
//   - Stimulus: drop aresetn with 10 beats in flight.
//   - Expected: all reset values hold immediately; next message output is correct with no stale beats.

Source files
------------

// File: rtl/aes_ctr_sched.sv
// aes_ctr_sched: CTR-mode sequencer for a free-running, fixed-latency AES-256 core.
// Issues one counter block per accepted plaintext beat and holds the key stable
// for the whole message. Returning keystream is realigned with the buffered
// plaintext, and the XOR of the two is streamed out with backpressure.
// Optional statistics counters: define AES_CTR_STATS_EN.
module aes_ctr_sched #(
  parameter int AES_LAT    = 29,
  parameter int FIFO_DEPTH = 32,
  parameter int CTR_W      = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [255:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         cfg_start,
  output logic         busy,
  output logic         done,
  output logic         ctr_wrap,
  input  logic [127:0] s_data,
  input  logic         s_last,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] core_state,
  output logic [255:0] core_key,
`ifdef AES_CTR_STATS_EN
  output logic [31:0]  stat_blocks,
  output logic [31:0]  stat_stall,
`endif
  input  logic [127:0] core_out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic [255:0]         key_q;
  logic [127:0]         ctr_q;
  logic [127:0]         core_state_q;
  logic                 wrap_q;
  logic [AES_LAT-1:0]   vsr_q;

  // Plaintext FIFO stores {data, last}; keystream FIFO stores core output.
  logic [128:0]         pt_mem [FIFO_DEPTH];
  logic [127:0]         ks_mem [FIFO_DEPTH];
  logic [AW:0]          pt_wr_q, pt_rd_q;
  logic [AW:0]          ks_wr_q, ks_rd_q;

  logic                 start, issue, ks_push, pop;
  logic                 pt_empty, pt_full, ks_empty;
  logic [128:0]         pt_head;
  logic [127:0]         ks_head;

  assign start    = (state_q == IDLE) && cfg_start;
  assign pt_empty = (pt_wr_q == pt_rd_q);
  assign pt_full  = (pt_wr_q[AW] != pt_rd_q[AW]) &&
                    (pt_wr_q[AW-1:0] == pt_rd_q[AW-1:0]);
  assign ks_empty = (ks_wr_q == ks_rd_q);

  assign s_ready  = (state_q == RUN) && !pt_full;
  assign issue    = s_valid && s_ready;
  assign ks_push  = vsr_q[AES_LAT-1];
  assign m_valid  = !ks_empty;
  assign pop      = m_valid && m_ready;

  assign pt_head  = pt_mem[pt_rd_q[AW-1:0]];
  assign ks_head  = ks_mem[ks_rd_q[AW-1:0]];

  // Gate with m_valid so an empty FIFO never exposes uninitialised storage.
  assign m_data     = m_valid ? (pt_head[128:1] ^ ks_head) : '0;
  assign m_last     = m_valid && pt_head[0];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign ctr_wrap   = wrap_q;
  assign core_state = core_state_q;
  assign core_key   = key_q;

  // FSM state register and the registered done pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!aresetn) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: start, last-beat hand-off to drain, drain completion.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:  if (cfg_start) state_d = RUN;
      RUN:   if (issue && s_last) state_d = DRAIN;
      DRAIN: begin
        if (pt_empty && ks_empty && (vsr_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Key, counter, wrap flag, core input block and the in-flight valid line.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      key_q        <= '0;
      ctr_q        <= '0;
      wrap_q       <= 1'b0;
      core_state_q <= '0;
      vsr_q        <= '0;
    end else begin
      vsr_q <= {vsr_q[AES_LAT-2:0], issue};
      if (start) begin
        key_q  <= cfg_key;
        ctr_q  <= cfg_iv;
        wrap_q <= 1'b0;
      end else if (issue) begin
        core_state_q       <= ctr_q;
        ctr_q[CTR_W-1:0]   <= ctr_q[CTR_W-1:0] + CTR_W'(1);
        if (&ctr_q[CTR_W-1:0]) wrap_q <= 1'b1;
      end
    end
  end

  // FIFO pointers; both FIFOs pop together on an output handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pt_wr_q <= '0;
      pt_rd_q <= '0;
      ks_wr_q <= '0;
      ks_rd_q <= '0;
    end else begin
      if (issue)   pt_wr_q <= pt_wr_q + (AW+1)'(1);
      if (ks_push) ks_wr_q <= ks_wr_q + (AW+1)'(1);
      if (pop) begin
        pt_rd_q <= pt_rd_q + (AW+1)'(1);
        ks_rd_q <= ks_rd_q + (AW+1)'(1);
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge aclk) begin
    // NOTE: storage arrays are not reset; the reset pointers mark them empty
    // and m_data is gated while empty.
    if (issue)   pt_mem[pt_wr_q[AW-1:0]] <= {s_data, s_last};
    if (ks_push) ks_mem[ks_wr_q[AW-1:0]] <= core_out;
  end

`ifdef AES_CTR_STATS_EN
  logic [31:0] stat_blocks_q, stat_stall_q;

  // Saturating output-handshake and input-stall counters, cleared on start.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_blocks_q <= '0;
      stat_stall_q  <= '0;
    end else if (start) begin
      stat_blocks_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (pop && !(&stat_blocks_q)) stat_blocks_q <= stat_blocks_q + 32'd1;
      if ((state_q == RUN) && s_valid && !s_ready && !(&stat_stall_q))
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_blocks = stat_blocks_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_aes_ctr_sched.sv
// Testbench for aes_ctr_sched. A stand-in core with fixed latency returns a
// known FIPS-197 ciphertext for the reference key/block and a simple keyed mix
// otherwise; a scoreboard predicts every ciphertext beat from the CTR rule.
module tb_aes_ctr_sched;

  localparam int AES_LAT    = 29;
  localparam int FIFO_DEPTH = 32;
  localparam int CTR_W      = 32;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_IV = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [255:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_start = 1'b0;
  logic         busy, done, ctr_wrap;
  logic [127:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] m_data;
  logic         m_last, m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] core_state;
  logic [255:0] core_key;
  logic [127:0] core_out;
`ifdef AES_CTR_STATS_EN
  logic [31:0]  stat_blocks, stat_stall;
`endif

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int seq = 0;
  bit rand_ready = 1'b0;
  logic [255:0] run_key = '0;
  logic [127:0] run_ctr = '0;
  logic [128:0] exp_q [$];

  aes_ctr_sched #(
    .AES_LAT(AES_LAT), .FIFO_DEPTH(FIFO_DEPTH), .CTR_W(CTR_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_start(cfg_start),
    .busy(busy), .done(done), .ctr_wrap(ctr_wrap),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .core_state(core_state), .core_key(core_key),
`ifdef AES_CTR_STATS_EN
    .stat_blocks(stat_blocks), .stat_stall(stat_stall),
`endif
    .core_out(core_out)
  );

  always #5 aclk = ~aclk;

  // Keystream of the stand-in core.
  function automatic logic [127:0] ks_fn(input logic [127:0] blk, input logic [255:0] key);
    logic [127:0] lo;
    if (key == FIPS_KEY && blk == FIPS_IV) return FIPS_CT;
    lo = key[127:0];
    return blk ^ key[255:128] ^ {lo[119:0], lo[127:120]};
  endfunction

  // Stand-in core: a block loaded onto core_state at edge t is presented on
  // core_out just after edge t+AES_LAT-1, where the sequencer captures it.
  logic [383:0] core_pipe [AES_LAT-1];
  always @(posedge aclk) begin
    core_pipe[0] <= {core_key, core_state};
    for (int i = 1; i < AES_LAT-1; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_out = ks_fn(core_pipe[AES_LAT-2][127:0], core_pipe[AES_LAT-2][383:128]);

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [31:0] w;
    w = n;
    return {w ^ 32'h0f0f0f0f, ~w, w + 32'h12345678, w};
  endfunction

  // Scoreboard: predicts each accepted beat, checks each output handshake.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_valid && s_ready) begin
        exp_q.push_back({s_data ^ ks_fn(run_ctr, run_key), s_last});
        run_ctr[CTR_W-1:0] = run_ctr[CTR_W-1:0] + 1;
        acc_cnt++;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("stream", {m_data, m_last}, exp_q.pop_front());
        out_cnt++;
      end
    end
  end

  // Random output backpressure, applied well after the edge.
  always @(posedge aclk) begin
    #3;
    if (rand_ready) m_ready = 1'($urandom_range(1));
  end

  task automatic check_reset(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_wrap"}, ctr_wrap, 0);
    check({p, "_s_ready"}, s_ready, 0);
    check({p, "_m_valid"}, m_valid, 0);
    check({p, "_m_last"}, m_last, 0);
    check({p, "_m_data"}, m_data, 0);
    check({p, "_core_state"}, core_state, 0);
    check({p, "_core_key"}, core_key, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic start_msg(input logic [255:0] k, input logic [127:0] iv);
    check("idle_before_start", busy, 0);
    cfg_key = k; cfg_iv = iv; cfg_start = 1'b1;
    run_key = k; run_ctr = iv;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_beats(input int n, input int pct, input bit end_msg);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n) begin
      s_data  = pat(seq);
      s_last  = end_msg && (i == n-1);
      s_valid = ($urandom_range(99) < pct);
      @(negedge aclk);
      acc = s_valid && s_ready;
      @(posedge aclk); #1;
      if (acc) begin i++; seq++; guard = 0; end
      else guard++;
      if (guard > 3000) begin check("send_timeout", 0, 1); break; end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    bit seen = 1'b0;
    while (n < 6000) begin
      @(negedge aclk);
      if (done) begin seen = 1'b1; break; end
      n++;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("drained", exp_q.size(), 0);
      @(negedge aclk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    int base;

    // Reset, with cfg_start held high throughout: reset must win.
    cfg_start = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check_reset("rst");
    cfg_start = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("idle_after_rst", busy, 0);

    // FIPS-197 single-beat message.
    m_ready = 1'b1;
    start_msg(FIPS_KEY, FIPS_IV);
    s_data = '0; s_last = 1'b1; s_valid = 1'b1;
    @(negedge aclk);
    check("fips_s_ready", s_ready, 1);
    @(posedge aclk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    check("fips_core_state", core_state, FIPS_IV);
    check("fips_core_key", core_key, FIPS_KEY);
    check("fips_drain_busy", busy, 1);
    lat = 0; seen = 1'b0;
    while (lat < 200) begin
      @(posedge aclk);
      lat++;
      @(negedge aclk);
      if (m_valid) begin seen = 1'b1; break; end
    end
    // Edges after acceptance; m_valid rises in cycle AES_LAT+1 counting the
    // acceptance cycle as cycle 0.
    check("fips_latency", lat, AES_LAT);
    check("fips_m_data", m_data, FIPS_CT);
    check("fips_m_last", m_last, 1);
    wait_done();

    // Counter wrap over three beats.
    start_msg(256'h1111, {96'ha5a5a5a5_5a5a5a5a_c3c3c3c3, 32'hffffffff});
    check("wrap_clear_start", ctr_wrap, 0);
    for (int i = 0; i < 3; i++) begin
      logic [127:0] exp_cs;
      logic [31:0] lo;
      lo = 32'hffffffff + i;
      exp_cs = {96'ha5a5a5a5_5a5a5a5a_c3c3c3c3, lo};
      s_data = pat(seq); seq++;
      s_last = (i == 2); s_valid = 1'b1;
      @(negedge aclk);
      check($sformatf("wrap_rdy%0d", i), s_ready, 1);
      @(posedge aclk); #1;
      check($sformatf("wrap_cs%0d", i), core_state, exp_cs);
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_done();
    check("wrap_sticky", ctr_wrap, 1);

    // Backpressure: 40 beats offered with the output stalled.
    m_ready = 1'b0;
    base = acc_cnt;
    start_msg({128'hfeed, 128'hbeef}, {96'h0, 32'h10});
    check("wrap_cleared", ctr_wrap, 0);
    fork
      send_beats(40, 100, 1'b1);
    join_none
    repeat (60) @(posedge aclk);
    @(negedge aclk);
    check("bp_accepted", acc_cnt - base, FIFO_DEPTH);
    check("bp_s_ready", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    check("bp_hold", {m_data, m_last}, exp_q[0]);
    @(negedge aclk);
    check("bp_hold2", {m_data, m_last}, exp_q[0]);
    @(posedge aclk); #1;
    m_ready = 1'b1;
    wait fork;
    base = out_cnt;
    wait_done();
    check("bp_total_out", out_cnt, acc_cnt);
    check("bp_total_acc", acc_cnt - (seq - 40) + 0, acc_cnt - seq + 40);

    // Random handshakes, 1000 beats.
    base = out_cnt;
    start_msg({128'h0123456789abcdef, 128'h55aa}, {96'h77, 32'h0});
    rand_ready = 1'b1;
    send_beats(1000, 50, 1'b1);
    wait_done();
    rand_ready = 1'b0;
    m_ready = 1'b1;
    check("rand_out_count", out_cnt - base, 1000);

    // cfg_start mid-message is ignored; next start uses the new key.
    base = out_cnt;
    start_msg({128'haaaa, 128'h1}, {96'h9, 32'h100});
    send_beats(3, 100, 1'b0);
    cfg_key = {128'hbbbb, 128'h2}; cfg_iv = {96'h8, 32'h200}; cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    check("stray_busy", busy, 1);
    check("stray_key", core_key, {128'haaaa, 128'h1});
    send_beats(3, 100, 1'b1);
    wait_done();
    check("stray_out_count", out_cnt - base, 6);
    start_msg({128'hbbbb, 128'h2}, {96'h8, 32'h200});
    check("new_key", core_key, {128'hbbbb, 128'h2});
    send_beats(2, 100, 1'b1);
    wait_done();

    // Reset with ten beats in flight.
    m_ready = 1'b0;
    start_msg({128'hcccc, 128'h3}, {96'h6, 32'h300});
    send_beats(10, 100, 1'b0);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    check_reset("midrst");
    exp_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    m_ready = 1'b1;
    base = out_cnt;
    start_msg({128'hdddd, 128'h4}, {96'h5, 32'h400});
    send_beats(4, 100, 1'b1);
    wait_done();
    check("post_rst_count", out_cnt - base, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
